// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data memory interface.
// Contents:
//   size_e   - access size encoding as presented on req_size
//   state_e  - bus master FSM states
//   BE_*     - Avalon byteenable lane patterns
package mem_if_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/byte_lane_encoder.sv
// Combinational lane encoder for stores and alignment checking.
// Ports:
//   size       in  access size
//   addr_lo    in  byte address bits [1:0]
//   wdata      in  store data (low byte/half used for byte/half)
//   byteenable out Avalon byteenable for the addressed lanes
//   writedata  out store data replicated across all lanes
//   misalign   out half on odd address, word not word aligned, or illegal size
module byte_lane_encoder
  import mem_if_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic        misalign
);

  // Lane select, data replication and alignment check per access size.
  always_comb begin
    byteenable = BE_NONE;
    writedata  = wdata;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteenable = BE_BYTE0 << addr_lo;
        writedata  = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        byteenable = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        writedata  = {2{wdata[15:0]}};
        misalign   = addr_lo[0];
      end
      SZ_WORD: begin
        byteenable = BE_WORD;
        writedata  = wdata;
        misalign   = (addr_lo != 2'b00);
      end
      default: begin
        byteenable = BE_NONE;
        writedata  = wdata;
        misalign   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_interface.sv
// Load/store bus master between the execute stage and an Avalon-style data memory.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req_read/req_write      load/store request, held until done
//   req_size/addr/wdata     access size, byte address, store data
//   stall                   high while an accepted access is incomplete
//   done                    one-cycle completion pulse; fault flags valid with it
//   data_readdata           last loaded full word
//   byte_addressing         addr[1:0] of the last completed load
//   misalign_fault          alignment/illegal-request fault (with done)
//   bus_error               waitrequest timeout (with done)
//   avm_*                   Avalon-MM master port
module data_mem_interface
  import mem_if_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] data_readdata,
  output logic [1:0]  byte_addressing,
  output logic        misalign_fault,
  output logic        bus_error,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  // Abort happens on the MAX_WAIT-th consecutive waitrequest cycle.
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

  state_e        state_r, state_nxt_s;
  logic [31:0]   addr_r, wdata_r, rdata_r;
  logic [3:0]    be_r;
  logic [1:0]    byte_addr_r;
  logic          is_read_r, misalign_r, bus_err_r;
  logic [CW-1:0] wait_cnt_r;

  logic [3:0]    enc_be_s;
  logic [31:0]   enc_wdata_s;
  logic          enc_misalign_s;
  logic          req_any_s, fault_s;
  logic          stall_s, strobe_s, capture_s, cnt_inc_s, cnt_clr_s, abort_s, load_data_s;

  // Encoding is done on the live request so the lane pattern is captured once at accept.
  byte_lane_encoder u_enc (
    .size       (size_e'(req_size)),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .byteenable (enc_be_s),
    .writedata  (enc_wdata_s),
    .misalign   (enc_misalign_s)
  );

  assign req_any_s = req_read | req_write;
  assign fault_s   = enc_misalign_s | (req_read & req_write);

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    strobe_s    = 1'b0;
    capture_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    cnt_clr_s   = 1'b0;
    abort_s     = 1'b0;
    load_data_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Stall is raised in the request cycle itself; reset_n gating keeps it
        // low while reset is asserted even if the CPU still holds a request.
        stall_s = req_any_s & reset_n;
        if (req_any_s) begin
          capture_s   = 1'b1;
          state_nxt_s = fault_s ? ST_DONE : ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s  = 1'b1;
        strobe_s = 1'b1;
        if (!avm_waitrequest) begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = is_read_r ? ST_RESP : ST_DONE;
        end else if ((MAX_WAIT != 0) && (wait_cnt_r == LAST_CNT)) begin
          abort_s     = 1'b1;
          cnt_clr_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_RESP: begin
        stall_s     = 1'b1;
        load_data_s = 1'b1;
        state_nxt_s = ST_DONE;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Captured request, fault flags, read data and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      be_r        <= 4'b0000;
      is_read_r   <= 1'b0;
      misalign_r  <= 1'b0;
      bus_err_r   <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      byte_addr_r <= 2'b00;
      wait_cnt_r  <= '0;
    end else begin
      if (capture_s) begin
        addr_r     <= req_addr;
        wdata_r    <= enc_wdata_s;
        be_r       <= enc_be_s;
        is_read_r  <= req_read;
        misalign_r <= fault_s;
        bus_err_r  <= 1'b0;
      end
      if (abort_s) begin
        bus_err_r <= 1'b1;
      end
      // Only a successful load updates the read word and its byte offset.
      if (load_data_s) begin
        rdata_r     <= avm_readdata;
        byte_addr_r <= addr_r[1:0];
      end
      if (cnt_clr_s) begin
        wait_cnt_r <= '0;
      end else if (cnt_inc_s) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end
    end
  end

  assign stall           = stall_s;
  assign done            = (state_r == ST_DONE);
  assign misalign_fault  = done & misalign_r;
  assign bus_error       = done & bus_err_r;
  assign data_readdata   = rdata_r;
  assign byte_addressing = byte_addr_r;
  assign avm_address     = {addr_r[31:2], 2'b00};
  assign avm_read        = strobe_s & is_read_r;
  assign avm_write       = strobe_s & ~is_read_r;
  assign avm_writedata   = wdata_r;
  assign avm_byteenable  = be_r;

endmodule
